// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host types, command bytes and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 frames carry odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronizer, clock glitch filter and falling-edge strobe
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic clk_filt,
    output logic data_sync,
    output logic clk_fall
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);

    logic [1:0]    clk_meta;
    logic [1:0]    data_meta;
    logic          clk_sync;
    logic [FW-1:0] filt_cnt;

    assign clk_sync  = clk_meta[1];
    assign data_sync = data_meta[1];

    // Two-flop synchronizers; idle PS/2 lines are high so they reset to 1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk};
            data_meta <= {data_meta[0], ps2_data};
        end
    end

    // Accept a new clock level only after it differs from the filtered level for FILTER_CYCLES samples in a row
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_cnt <= '0;
            clk_filt <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            if (clk_sync == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_cnt <= '0;
                clk_filt <= clk_sync;
                clk_fall <= ~clk_sync;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check and timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok
);

    import ps2_pkg::*;

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [7:0]    data_q, data_n;
    logic          parity_q, parity_n;
    logic          ack_q, ack_n;
    logic          clk_oe_n, data_oe_n, done_n, ack_ok_n;
    logic          timeout;

    logic clk_filt;
    logic data_sync;
    logic clk_fall;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .clk_filt (clk_filt),
        .data_sync(data_sync),
        .clk_fall (clk_fall)
    );

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // State, counters and registered line enables; reset releases both lines and suppresses done
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            data_q      <= '0;
            parity_q    <= 1'b0;
            ack_q       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            data_q      <= data_n;
            parity_q    <= parity_n;
            ack_q       <= ack_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done        <= done_n;
            ack_ok      <= ack_ok_n;
        end
    end

    // Next-state logic: inhibit, request-to-send, shift on device falling edges, ACK sample, wait for idle bus
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        data_n    = data_q;
        parity_n  = parity_q;
        ack_n     = ack_q;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        ack_ok_n  = 1'b0;
        timeout   = 1'b0;

        case (state)
            IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    data_n   = tx_data;
                    parity_n = odd_parity(tx_data);
                    clk_oe_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = INHIBIT;
                end
            end
            INHIBIT: begin
                // Our own clock pull-down produces a falling edge here; it is deliberately ignored
                if (cnt == INH_LAST) begin
                    data_oe_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = START;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            START: begin
                clk_oe_n  = 1'b0;
                cnt_n     = '0;
                bit_idx_n = '0;
                state_n   = SHIFT;
            end
            SHIFT: begin
                if (clk_fall) begin
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 4'd1;
                    if (bit_idx < 4'd8) begin
                        data_oe_n = ~data_q[bit_idx[2:0]];
                    end else if (bit_idx == 4'd8) begin
                        data_oe_n = ~parity_q;
                    end else begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end
                end else if (cnt == TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_n   = ~data_sync;
                    cnt_n   = '0;
                    state_n = WAIT_IDLE;
                end else if (cnt == TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                    done_n   = 1'b1;
                    ack_ok_n = ack_q;
                    state_n  = IDLE;
                end else if (cnt == TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (timeout) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            done_n    = 1'b1;
            ack_ok_n  = 1'b0;
            cnt_n     = '0;
            state_n   = IDLE;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with an open-drain keyboard model
module tb_ps2_host_tx;

    localparam int TB_INH  = 20;
    localparam int TB_TO   = 400;
    localparam int TB_FILT = 8;
    localparam int HALF    = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok;
    logic       ps2_clk_line, ps2_data_line;

    // Open-drain bus: a line is low if either side pulls it
    assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_line = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(TB_INH),
        .TIMEOUT_CYCLES(TB_TO),
        .FILTER_CYCLES (TB_FILT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk    (ps2_clk_line),
        .ps2_data   (ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int accept_cnt = 0;
    int ready_in_busy = 0;
    logic last_ack = 1'b0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            last_ack <= ack_ok;
        end
        if (tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
        if (busy && tx_ready) ready_in_busy <= ready_in_busy + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand over one byte, then confirm clk_oe latency, the inhibit length and the START cycle
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!tx_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_send", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("clk_oe_latency", ps2_clk_oe, 1'b1);
        check("busy_after_accept", busy, 1'b1);
        k = 0;
        while (!ps2_data_oe && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("inhibit_cycles", k, TB_INH);
        check("clk_held_at_start", ps2_clk_oe, 1'b1);
        @(posedge clk);
        #1;
        check("clk_released", ps2_clk_oe, 1'b0);
        check("start_bit_driven", ps2_data_oe, 1'b1);
    endtask

    // Device side: wait for request-to-send, generate npulses clocks, sample data in each high phase
    task automatic kbd_model(input int npulses, input bit give_ack, input bit glitch,
                             output logic [8:0] frame, output logic stop_bit);
        int k;
        frame    = '0;
        stop_bit = 1'b0;
        k = 0;
        while (!(ps2_data_line == 1'b0 && ps2_clk_oe == 1'b0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("request_seen", (k < 100), 1'b1);
        repeat (20) @(negedge clk);
        for (int p = 1; p <= npulses; p++) begin
            if (p == 11) begin
                tx_valid = 1'b0;
                if (give_ack) dev_data = 1'b0;
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (glitch && p <= 10) begin
                repeat (15) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 18) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (p <= 9) frame[p-1] = ps2_data_line;
            if (p == 10) stop_bit = ps2_data_line;
            if (p == 11) dev_data = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         give_ack;
        bit         glitch;
        logic [8:0] exp_frame;
        logic       exp_ack;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [8:0] frame;
        logic       stop_bit;
        int         prev_done, prev_acc, k;

        // {data, device ACKs, glitch clock, expected {parity, D7..D0}, expected ack_ok}
        vecs[0] = '{8'hED, 1'b1, 1'b0, 9'b1_1110_1101, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0, 9'b0_0000_0001, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 9'b1_1111_1111, 1'b1};
        vecs[3] = '{8'hF4, 1'b0, 1'b0, 9'b0_1111_0100, 1'b0};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 9'b1_0011_1100, 1'b1};

        repeat (4) @(posedge clk);
        #1;
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_ok", ack_ok, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            prev_done = done_cnt;
            prev_acc  = accept_cnt;
            send_byte(vecs[i].data);
            if (vecs[i].glitch) begin
                // A new request and new data while busy must be ignored
                tx_data  = 8'h55;
                tx_valid = 1'b1;
            end
            kbd_model(11, vecs[i].give_ack, vecs[i].glitch, frame, stop_bit);
            k = 0;
            while (done_cnt == prev_done && k < 200) begin
                @(negedge clk);
                k++;
            end
            repeat (3) @(negedge clk);
            check($sformatf("frame_%0d", i), frame, vecs[i].exp_frame);
            check($sformatf("stop_%0d", i), stop_bit, 1'b1);
            check($sformatf("done_count_%0d", i), done_cnt - prev_done, 1);
            check($sformatf("ack_ok_%0d", i), last_ack, vecs[i].exp_ack);
            check($sformatf("accepts_%0d", i), accept_cnt - prev_acc, 1);
            check($sformatf("idle_clk_oe_%0d", i), ps2_clk_oe, 1'b0);
            check($sformatf("idle_data_oe_%0d", i), ps2_data_oe, 1'b0);
            check($sformatf("idle_ready_%0d", i), tx_ready, 1'b1);
        end
        check("ready_never_in_busy", ready_in_busy, 0);

        // Timeout: device never clocks; done must follow exactly TIMEOUT_CYCLES after entering SHIFT
        prev_done = done_cnt;
        send_byte(8'hF4);
        k = 0;
        while (!done && k < TB_TO + 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("timeout_cycles", k, TB_TO);
        check("timeout_done", done, 1'b1);
        check("timeout_ack_ok", ack_ok, 1'b0);
        check("timeout_clk_oe", ps2_clk_oe, 1'b0);
        check("timeout_data_oe", ps2_data_oe, 1'b0);
        repeat (5) @(negedge clk);
        check("timeout_done_count", done_cnt - prev_done, 1);

        // Reset during SHIFT after four falling edges: D3 of 0xA5 is 0, so data is pulled low
        repeat (20) @(negedge clk);
        send_byte(8'hA5);
        kbd_model(4, 1'b0, 1'b0, frame, stop_bit);
        check("mid_frame_bits", frame[3:0], 4'b0101);
        check("mid_data_oe_bit3", ps2_data_oe, 1'b1);
        prev_done = done_cnt;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_clk_oe", ps2_clk_oe, 1'b0);
        check("midrst_data_oe", ps2_data_oe, 1'b0);
        check("midrst_tx_ready", tx_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("midrst_no_done", done_cnt - prev_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, 5000, number of clk cycles PS/2 clock is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 750000, maximum clk cycles between consecutive device clock falling edges (15 ms at 50 MHz).
REQ-003 SHALL have parameter FILTER_CYCLES, 8, number of consecutive clk samples a PS/2 clock level must hold before it is accepted.
REQ-004 SHALL have port clk  input  1  system clock; the only clock domain.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port tx_data  input  8  command byte to send to the keyboard.
REQ-007 SHALL have port tx_valid  input  1  request; byte is accepted when tx_valid and tx_ready are both high.
REQ-008 SHALL have port tx_ready  output  1  high only in IDLE.
REQ-009 SHALL have port ps2_clk  input  1  raw PS/2 clock line level, asynchronous.
REQ-010 SHALL have port ps2_data  input  1  raw PS/2 data line level, asynchronous.
REQ-011 SHALL have port ps2_clk_oe  output  1  1 = pull PS/2 clock low; 0 = release the line.
REQ-012 SHALL have port ps2_data_oe  output  1  1 = pull PS/2 data low; 0 = release the line.
REQ-013 SHALL have port busy  output  1  high from acceptance until return to IDLE; the receiver side ignores bytes while it is high.
REQ-014 SHALL have port done  output  1  single-cycle pulse at completion of a transfer.
REQ-015 SHALL have port ack_ok  output  1  valid with done; 1 = device ACK seen, 0 = timeout or missing ACK.

Function
REQ-016 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer.
REQ-017 SHALL update the filtered clock only after FILTER_CYCLES identical synchronized samples.
REQ-018 SHALL treat a 1-to-0 transition of the filtered clock as a falling edge.
REQ-019 SHALL latch tx_data on the handshake cycle and compute odd parity: parity bit = ~^tx_data.
REQ-020 SHALL implement these states: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-021 IDLE: both outputs enable lines SHALL be 0; on handshake the block SHALL go to INHIBIT with clk_oe=1.
REQ-022 INHIBIT: after INHIBIT_CYCLES cycles the block SHALL set data_oe=1 and enter START.
REQ-023 START: one cycle later the block SHALL set clk_oe=0 and enter SHIFT with bit index 0.
REQ-024 SHIFT: on falling edges 1..8 the block SHALL drive data_oe = ~D[n-1], sending LSB first.
REQ-025 SHIFT: on falling edge 9 the block SHALL drive data_oe = ~parity.
REQ-026 SHIFT: on falling edge 10 the block SHALL set data_oe=0 (stop bit) and enter ACK.
REQ-027 ACK: on the next falling edge the block SHALL record ack = (synchronized data == 0) and enter WAIT_IDLE.
REQ-028 WAIT_IDLE: once filtered clock and synchronized data are both 1, the block SHALL pulse done with ack_ok = ack and return to IDLE.
REQ-029 Timeout: in START, SHIFT, ACK and WAIT_IDLE, a cycle counter SHALL reset on each falling edge (WAIT_IDLE: on entry).
REQ-030 On reaching TIMEOUT_CYCLES the block SHALL release both lines, pulse done with ack_ok=0, and go to IDLE.
REQ-031 tx_valid SHALL be ignored while busy, and tx_data changes after acceptance SHALL have no effect.
REQ-032 A falling edge seen during INHIBIT SHALL be ignored.
REQ-033 Latency: clk_oe SHALL rise the cycle after the handshake.

Reset
REQ-034 When reset_n=0 at a clk edge, the block SHALL enter IDLE with clk_oe=0, data_oe=0, busy=0, done=0, ack_ok=0 and tx_ready=1, and SHALL clear all counters.
REQ-035 Reset mid-transfer SHALL release both lines on the next clk edge and SHALL NOT produce a done pulse.

Structure
REQ-036 A shared ps2 package SHALL hold the state enumeration and command constants (0xED set LEDs, 0xFF reset, 0xF4 enable).
REQ-037 A sub-module ps2_line_filter SHALL provide the synchronizer, glitch filter and falling-edge strobe; the receiver MAY reuse it.

Verification
REQ-038 Send 0xED with a keyboard model: data bits observed at the model SHALL be 1,0,1,1,0,1,1,1 with parity 1, followed by done=1 and ack_ok=1.
REQ-039 Send 0x01: parity bit SHALL be 0; send 0xFF: parity bit SHALL be 1.
REQ-040 With no device clocking after START: after TIMEOUT_CYCLES, done=1, ack_ok=0, and both oe=0.
REQ-041 With the model omitting the ACK (data high at edge 11): done=1, ack_ok=0.
REQ-042 Assert reset_n=0 during SHIFT bit 4: both oe=0 and tx_ready=1 on the next cycle, with no done pulse.
REQ-043 Apply 3-cycle glitches on ps2_clk with FILTER_CYCLES=8: no bit advance SHALL occur, and tx_valid held during busy SHALL not be accepted.
